// File: rtl/life_ctrl.sv
// life_ctrl -- sequencing controller for an 8x8 Game of Life engine.
//
// The grid register lives here; the neighbour-counting evolve logic is an
// external combinational block that reads `grid` and returns `grid_evolve`.
// A run advances one generation every STEP_DIV clocks until the generation
// limit is reached or `stop` is seen.
//
// Optional feature: define LIFE_AUTO_HALT_EN to also end a run when the
// pattern stops changing (stable) or dies out (extinct). Without it the
// stable/extinct outputs are constant 0.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high
//   seed         in  64   initial grid, bit index = 8*row + col
//   load         in   1   copy seed into grid (IDLE only)
//   start        in   1   begin a run (IDLE only; load has priority)
//   stop         in   1   abort a run (RUN only)
//   gen_limit    in   8   generations per run, 0 = unlimited, latched on start
//   grid_evolve  in  64   next generation of `grid` from the evolve datapath
//   grid         out 64   current grid
//   busy         out  1   high while running
//   done         out  1   one-cycle pulse when a run ends
//   stable       out  1   run ended because the pattern stopped changing
//   extinct      out  1   run ended with an empty grid
//   gen_count    out  8   generations committed since the last load
module life_ctrl #(
    parameter int STEP_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] seed,
    input  logic        load,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  gen_limit,
    input  logic [63:0] grid_evolve,
    output logic [63:0] grid,
    output logic        busy,
    output logic        done,
    output logic        stable,
    output logic        extinct,
    output logic [7:0]  gen_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [63:0] grid_q, grid_d;
    logic [7:0]  gen_q, gen_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  limit_q, limit_d;
    logic        step_edge;
`ifdef LIFE_AUTO_HALT_EN
    logic        stable_q, stable_d;
    logic        extinct_q, extinct_d;
`endif

    assign step_edge = (step_q == STEP_LAST);

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        gen_d   = gen_q;
        step_d  = step_q;
        limit_d = limit_q;
`ifdef LIFE_AUTO_HALT_EN
        stable_d  = stable_q;
        extinct_d = extinct_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    grid_d = seed;
                    gen_d  = 8'd0;
`ifdef LIFE_AUTO_HALT_EN
                    stable_d  = 1'b0;
                    extinct_d = 1'b0;
`endif
                end else if (start) begin
                    limit_d = gen_limit;
                    step_d  = 8'd0;
                    state_d = ST_RUN;
`ifdef LIFE_AUTO_HALT_EN
                    stable_d  = 1'b0;
                    extinct_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (step_edge) begin
                    step_d = 8'd0;
`ifdef LIFE_AUTO_HALT_EN
                    if (grid_evolve == grid_q) begin
                        // Fixed point: keep grid and count as they are.
                        stable_d  = 1'b1;
                        extinct_d = (grid_q == 64'd0);
                        state_d   = ST_DONE;
                    end else begin
                        grid_d = grid_evolve;
                        gen_d  = gen_q + 8'd1;
                        // Extinction outranks the generation limit.
                        if (grid_evolve == 64'd0) begin
                            extinct_d = 1'b1;
                            state_d   = ST_DONE;
                        end else if (limit_q != 8'd0 && gen_d == limit_q) begin
                            state_d = ST_DONE;
                        end
                    end
`else
                    grid_d = grid_evolve;
                    gen_d  = gen_q + 8'd1;
                    if (limit_q != 8'd0 && gen_d == limit_q) begin
                        state_d = ST_DONE;
                    end
`endif
                end else begin
                    step_d = step_q + 8'd1;
                end
                // A stop coinciding with a step edge still lets that step commit.
                if (stop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grid_q  <= 64'd0;
            gen_q   <= 8'd0;
            step_q  <= 8'd0;
            limit_q <= 8'd0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            gen_q   <= gen_d;
            step_q  <= step_d;
            limit_q <= limit_d;
        end
    end

`ifdef LIFE_AUTO_HALT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign stable  = stable_q;
    assign extinct = extinct_q;
`else
    assign stable  = 1'b0;
    assign extinct = 1'b0;
`endif

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl. The bench supplies the evolve datapath
// (standard Life rules, cells outside the 8x8 board are dead) and predicts
// every run from the generation sequence of the seed.
module tb_life_ctrl;

    localparam int N = 4;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0E00; // bits 9,10,11
    localparam logic [63:0] BLINK_V = 64'h0000_0000_0004_0404; // bits 2,10,18

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [63:0] seed = 64'd0;
    logic [7:0]  gen_limit = 8'd0;
    logic [63:0] grid_evolve;
    logic [63:0] grid;
    logic        busy, done, stable, extinct;
    logic [7:0]  gen_count;

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] r;
        int n;
        r = 64'd0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && row + dr >= 0 && row + dr < 8 &&
                            col + dc >= 0 && col + dc < 8)
                            n += g[8*(row+dr)+col+dc] ? 1 : 0;
                    end
                end
                r[8*row+col] = (n == 3) || (g[8*row+col] && n == 2);
            end
        end
        return r;
    endfunction

    assign grid_evolve = life_next(grid);

    life_ctrl #(.STEP_DIV(N)) dut (
        .clk(clk), .reset(reset), .seed(seed), .load(load), .start(start),
        .stop(stop), .gen_limit(gen_limit), .grid_evolve(grid_evolve),
        .grid(grid), .busy(busy), .done(done), .stable(stable),
        .extinct(extinct), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #2;
        checks++; if (grid !== 64'd0) begin errors++; $display("FAIL reset_grid got %h want 0", grid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (gen_count !== 8'd0) begin errors++; $display("FAIL reset_gen got %0d want 0", gen_count); end
        checks++; if (stable !== 1'b0 || extinct !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", stable, extinct); end
        tick(); tick();
        reset = 1'b0;
        do_load(64'hDEAD_BEEF_0123_4567);
        checks++; if (grid !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL post_reset_load got %h want %h", grid, 64'hDEAD_BEEF_0123_4567); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_blinker();
        do_load(BLINK_H);
        checks++; if (gen_count !== 8'd0) begin errors++; $display("FAIL blink_load_gen got %0d want 0", gen_count); end
        start = 1'b1; gen_limit = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 2*N + 1; k++) begin
            if (k > 0) tick();
            checks++; if (done !== (k == 2*N)) begin errors++; $display("FAIL blink_done k=%0d got %b want %b", k, done, k == 2*N); end
            checks++; if (busy !== (k < 2*N)) begin errors++; $display("FAIL blink_busy k=%0d got %b want %b", k, busy, k < 2*N); end
            if (k == N) begin
                checks++; if (grid !== BLINK_V) begin errors++; $display("FAIL blink_step1 got %h want %h", grid, BLINK_V); end
            end
        end
        checks++; if (grid !== BLINK_H) begin errors++; $display("FAIL blink_final got %h want %h", grid, BLINK_H); end
        checks++; if (gen_count !== 8'd2) begin errors++; $display("FAIL blink_gen got %0d want 2", gen_count); end
    endtask

    task automatic test_random();
        logic [63:0] s, g, nxt;
        logic [63:0] exp_g[0:5];
        int L, cnt, h, ek;
        bit st, ex, halted;
        for (int t = 0; t < 10; t++) begin
            s = {$urandom, $urandom} & {$urandom, $urandom};
            if (t == 0) s = 64'h0000_0000_0000_0303;   // still life
            if (t == 1) s = 64'h0000_0000_0800_0000;   // dies at once
            L = $urandom_range(1, 5);
            g = s; cnt = 0; h = 0; st = 0; ex = 0; halted = 0; exp_g[0] = s;
            while (!halted) begin
                h++;
                nxt = life_next(g);
`ifdef LIFE_AUTO_HALT_EN
                if (nxt == g) begin
                    st = 1; ex = (g == 64'd0); halted = 1;
                end else begin
                    g = nxt; cnt++; exp_g[cnt] = g;
                    if (g == 64'd0) begin ex = 1; halted = 1; end
                    else if (cnt == L) halted = 1;
                end
`else
                g = nxt; cnt++; exp_g[cnt] = g;
                if (cnt == L) halted = 1;
`endif
            end
            do_load(s);
            start = 1'b1; gen_limit = 8'(L);
            tick();
            start = 1'b0;
            for (int k = 0; k <= N*h + 1; k++) begin
                if (k > 0) tick();
                ek = k / N;
                if (ek > cnt) ek = cnt;
                checks++; if (done !== (k == N*h)) begin errors++; $display("FAIL rnd_done t=%0d k=%0d got %b", t, k, done); end
                checks++; if (busy !== (k < N*h)) begin errors++; $display("FAIL rnd_busy t=%0d k=%0d got %b", t, k, busy); end
                checks++; if (grid !== exp_g[ek]) begin errors++; $display("FAIL rnd_grid t=%0d k=%0d got %h want %h", t, k, grid, exp_g[ek]); end
                checks++; if (gen_count !== 8'(ek)) begin errors++; $display("FAIL rnd_gen t=%0d k=%0d got %0d want %0d", t, k, gen_count, ek); end
                checks++; if (stable !== ((k >= N*h) ? st : 1'b0)) begin errors++; $display("FAIL rnd_stable t=%0d k=%0d got %b", t, k, stable); end
                checks++; if (extinct !== ((k >= N*h) ? ex : 1'b0)) begin errors++; $display("FAIL rnd_extinct t=%0d k=%0d got %b", t, k, extinct); end
            end
        end
    endtask

    task automatic test_stop_reset();
        do_load(BLINK_H);
        start = 1'b1; gen_limit = 8'd0;
        tick();
        start = 1'b0;
        for (int k = 1; k < 2*N; k++) tick();
        stop = 1'b1;   // sampled on the second step edge
        tick();
        stop = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_edge_done got %b want 1", done); end
        checks++; if (grid !== BLINK_H) begin errors++; $display("FAIL stop_edge_grid got %h want %h", grid, BLINK_H); end
        checks++; if (gen_count !== 8'd2) begin errors++; $display("FAIL stop_edge_gen got %0d want 2", gen_count); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_idle got busy=%b done=%b want 0 0", busy, done); end
        // stop between step edges: no commit
        start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_mid_done got %b want 1", done); end
        checks++; if (grid !== BLINK_H || gen_count !== 8'd2) begin errors++; $display("FAIL stop_mid_hold got %h/%0d want %h/2", grid, gen_count, BLINK_H); end
        tick();
        // reset mid-step
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (grid !== 64'd0) begin errors++; $display("FAIL rst_mid_grid got %h want 0", grid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_state got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (gen_count !== 8'd0) begin errors++; $display("FAIL rst_mid_gen got %0d want 0", gen_count); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got %b want 0", busy); end
    endtask

    task automatic test_load_start();
        logic [63:0] r;
        r = {$urandom, $urandom} | 64'h1;
        seed = r; load = 1'b1; start = 1'b1; gen_limit = 8'd3;
        tick();
        load = 1'b0; start = 1'b0;
        checks++; if (grid !== r) begin errors++; $display("FAIL ls_grid got %h want %h", grid, r); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ls_busy got %b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ls_busy2 got %b want 0", busy); end
        do_load(BLINK_H);
        start = 1'b1; gen_limit = 8'd3;
        tick();
        seed = r; load = 1'b1; start = 1'b1;   // must be ignored while running
        tick();
        load = 1'b0; start = 1'b0;
        checks++; if (grid !== BLINK_H) begin errors++; $display("FAIL busy_load_grid got %h want %h", grid, BLINK_H); end
        for (int k = 2; k <= 3*N; k++) begin
            tick();
            checks++; if (done !== (k == 3*N)) begin errors++; $display("FAIL busy_run_done k=%0d got %b", k, done); end
        end
        checks++; if (grid !== BLINK_V || gen_count !== 8'd3) begin errors++; $display("FAIL busy_run_end got %h/%0d want %h/3", grid, gen_count, BLINK_V); end
        stop = 1'b1;
        tick(); tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_stop got busy=%b done=%b want 0 0", busy, done); end
    endtask

`ifdef LIFE_AUTO_HALT_EN
    task automatic test_auto_halt();
        do_load(64'h0303);
        start = 1'b1; gen_limit = 8'd0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= N; k++) tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL block_done got %b want 1", done); end
        checks++; if (stable !== 1'b1 || extinct !== 1'b0) begin errors++; $display("FAIL block_flags got %b%b want 10", stable, extinct); end
        checks++; if (gen_count !== 8'd0 || grid !== 64'h0303) begin errors++; $display("FAIL block_hold got %h/%0d want 303/0", grid, gen_count); end
        tick();
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL block_flag_hold got %b want 1", stable); end
        do_load(64'h0800_0000);
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL load_clears_flag got %b want 0", stable); end
        start = 1'b1; gen_limit = 8'd5;
        tick();
        start = 1'b0;
        for (int k = 1; k <= N; k++) tick();
        checks++; if (done !== 1'b1 || extinct !== 1'b1 || stable !== 1'b0) begin errors++; $display("FAIL lone_end got done=%b ext=%b st=%b want 1 1 0", done, extinct, stable); end
        checks++; if (grid !== 64'd0 || gen_count !== 8'd1) begin errors++; $display("FAIL lone_grid got %h/%0d want 0/1", grid, gen_count); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_blinker();
        test_random();
        test_stop_reset();
        test_load_start();
`ifdef LIFE_AUTO_HALT_EN
        test_auto_halt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_ctrl.md
LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4, meaning clock cycles per generation step (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port seed  input  64  initial 8x8 grid, bit index = 8*row + col.
REQ-005 SHALL have port load  input  1  copies seed into the grid register (honoured in IDLE only).
REQ-006 SHALL have port start  input  1  begins a run (honoured in IDLE only).
REQ-007 SHALL have port stop  input  1  aborts a run (honoured in RUN only).
REQ-008 SHALL have port gen_limit  input  8  generations to run; 0 means unlimited; latched on start.
REQ-009 SHALL have port grid_evolve  input  64  next-generation grid from the combinational evolve datapath.
REQ-010 SHALL have port grid  output  64  registered current grid, driven to the datapath.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a run ends.
REQ-013 SHALL have ports stable and extinct  output  1 each  termination-cause flags.
REQ-014 SHALL have port gen_count  output  8  generations committed since the last load.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; DONE lasts exactly one cycle, asserts done, then returns to IDLE.
REQ-016 In IDLE, load SHALL set grid<=seed, gen_count<=0, stable<=0, extinct<=0; if load and start are both high, load wins and start is ignored.
REQ-017 In IDLE, start (without load) SHALL latch gen_limit, clear the step counter, clear stable/extinct, and enter RUN next cycle.
REQ-018 In RUN, a step counter SHALL count 0..STEP_DIV-1; the cycle it equals STEP_DIV-1 is the step edge, and the counter wraps to 0.
REQ-019 At a step edge, grid SHALL load grid_evolve and gen_count SHALL increment by 1, wrapping 255->0.
REQ-020 After a commit, if the latched limit is nonzero and the new gen_count equals it, the FSM SHALL enter DONE.
REQ-021 A stop in RUN SHALL enter DONE next cycle; on a step edge, the step commits first, then the FSM stops; grid holds its value.
REQ-022 Outside step edges and load, grid and gen_count SHALL hold; load, start and stop outside their honoured states SHALL be ignored.
REQ-023 First result: with STEP_DIV=N and gen_limit=L>0, done SHALL pulse exactly N*L+1 cycles after the cycle start is sampled.

Reset
REQ-024 reset SHALL asynchronously force IDLE, grid=0, gen_count=0, step counter=0, busy=0, done=0, stable=0, extinct=0, including mid-run.
REQ-025 After reset deasserts, the first rising edge SHALL behave as a normal IDLE cycle.

Configuration
REQ-026 With macro LIFE_AUTO_HALT_EN defined, a step edge where grid_evolve==grid SHALL skip the commit, set stable=1, set extinct=1 if grid==0, and enter DONE.
REQ-027 With LIFE_AUTO_HALT_EN defined, a commit producing grid_evolve==0 SHALL set extinct=1 and enter DONE; this check has priority over the gen_limit check.
REQ-028 Without LIFE_AUTO_HALT_EN, stable and extinct SHALL be tied to 0, and runs SHALL end only on gen_limit or stop.
REQ-029 stable and extinct SHALL hold until the next load, start or reset.

Verification
REQ-030 Blinker: seed bits {9,10,11}, STEP_DIV=4, gen_limit=2, start -> after 1 step grid bits {2,10,18}; done at cycle 9; then grid bits {9,10,11}, gen_count=2.
REQ-031 Block, macro on: seed bits {0,1,8,9}, gen_limit=0 -> done after first step edge; stable=1, extinct=0, gen_count=0, grid unchanged.
REQ-032 Lone cell, macro on: seed bit 27, gen_limit=5 -> after 1 step grid=0, gen_count=1, extinct=1, done pulse.
REQ-033 Stop and reset mid-run: blinker, gen_limit=0, stop on a step edge -> commit, then done; rerun, assert reset mid-step -> grid=0, IDLE immediately.
REQ-034 Load+start same cycle in IDLE -> grid=seed, FSM stays IDLE, busy=0; start while busy and load while busy -> ignored.
